// File: rtl/sc_fetch.sv
// Shortcut-data fetch engine: splits a word-count job into memory bursts, gates each
// burst on downstream FIFO credits, and forwards returned words to the shortcut FIFO.
module sc_fetch #(
    parameter int BITWIDTH   = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                           clk_data,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic [LEN_W-1:0]               num_words,
    output logic                           busy,
    output logic                           done,
    output logic                           mem_rd_req,
    output logic [ADDR_W-1:0]              mem_rd_addr,
    output logic [$clog2(BURST_LEN):0]     mem_rd_len,
    input  logic                           mem_rd_ack,
    input  logic [BITWIDTH*16-1:0]         mem_rd_data,
    input  logic                           mem_rd_vld,
    input  logic                           sc_credit_rtn,
    output logic [BITWIDTH*16-1:0]         sc_in,
    output logic                           sc_in_vld
);
    localparam int DW  = BITWIDTH * 16;
    localparam int BLW = $clog2(BURST_LEN) + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int SW  = CW + 1;

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [BLW-1:0]    len_q, len_d;
    logic [BLW-1:0]    rx_cnt_q, rx_cnt_d;
    logic [CW-1:0]     credits_q, credits_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              req_q, req_d;
    logic [DW-1:0]     sc_in_q, sc_in_d;
    logic              sc_in_vld_q, sc_in_vld_d;
    logic              ack_fire;
    logic [SW-1:0]     credit_sum;

    function automatic logic [BLW-1:0] burst_of(input logic [LEN_W-1:0] rem);
        if (rem >= LEN_W'(BURST_LEN))
            return BLW'(BURST_LEN);
        else
            return rem[BLW-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        rx_cnt_d    = rx_cnt_q;
        sc_in_d     = sc_in_q;
        sc_in_vld_d = 1'b0;
        // len_q always equals burst_of(remain_q), so it doubles as the current burst length
        ack_fire    = req_q && mem_rd_ack && (state_q == REQ);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = num_words;
                    state_d  = (num_words == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (ack_fire) begin
                    addr_d   = addr_q + (ADDR_W'(len_q) << 6);
                    remain_d = remain_q - LEN_W'(len_q);
                    rx_cnt_d = len_q;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (mem_rd_vld) begin
                    sc_in_vld_d = 1'b1;
                    sc_in_d     = mem_rd_data;
                    rx_cnt_d    = rx_cnt_q - 1'b1;
                    if (rx_cnt_q == BLW'(1))
                        state_d = (remain_q != '0) ? REQ : DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Return and reservation share one adder so a same-cycle pair is never lost.
        credit_sum = SW'(credits_q) + SW'(sc_credit_rtn) - (ack_fire ? SW'(len_q) : '0);
        credits_d  = (credit_sum > SW'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : credit_sum[CW-1:0];

        len_d  = burst_of(remain_d);
        busy_d = (state_d == REQ) || (state_d == RECV);
        done_d = (state_d == DONE);
        req_d  = (state_d == REQ) && (credits_d >= CW'(len_d));
    end

    always_ff @(posedge clk_data) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            len_q       <= '0;
            rx_cnt_q    <= '0;
            credits_q   <= CW'(FIFO_DEPTH);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_q       <= 1'b0;
            sc_in_q     <= '0;
            sc_in_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            len_q       <= len_d;
            rx_cnt_q    <= rx_cnt_d;
            credits_q   <= credits_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_q       <= req_d;
            sc_in_q     <= sc_in_d;
            sc_in_vld_q <= sc_in_vld_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_req  = req_q;
    assign mem_rd_addr = addr_q;
    assign mem_rd_len  = len_q;
    assign sc_in       = sc_in_q;
    assign sc_in_vld   = sc_in_vld_q;

endmodule

// File: tb/tb_sc_fetch.sv
// Randomized bench for sc_fetch: a memory responder and FIFO drain driven per cycle,
// checked against a job-level model (burst plan, word order, credit count).
module tb_sc_fetch;
    localparam int DW = 512;

    logic           clk_data = 1'b0;
    logic           rst, start, busy, done, mem_rd_req, mem_rd_ack, mem_rd_vld;
    logic           sc_credit_rtn, sc_in_vld;
    logic [31:0]    base_addr, mem_rd_addr;
    logic [15:0]    num_words;
    logic [4:0]     mem_rd_len;
    logic [DW-1:0]  mem_rd_data, sc_in;

    sc_fetch dut (
        .clk_data(clk_data), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .mem_rd_req(mem_rd_req),
        .mem_rd_addr(mem_rd_addr), .mem_rd_len(mem_rd_len), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .mem_rd_vld(mem_rd_vld), .sc_credit_rtn(sc_credit_rtn),
        .sc_in(sc_in), .sc_in_vld(sc_in_vld)
    );

    always #5 clk_data = ~clk_data;

    typedef struct { logic [31:0] addr; int len; } burst_t;

    int total = 0, bad = 0;
    burst_t        exp_bursts[$];
    logic [DW-1:0] exp_data[$];
    int  pending = 0, model_credits = 128, fifo_occ = 0, delivered = 0, job_num = 0;
    int  ack_pct = 100, vld_pct = 100, rtn_pct = 100, ack_wait = 0, req_age = 0, rtn_force = 0;
    bit  job_active = 0, drove_vld = 0, rtn_en = 1, junk_en = 0, rtn_on_ack = 0, chk5 = 0;
    bit  start_req = 0;
    logic [31:0] start_base;
    int  start_num;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Burst plan straight from the job: chunks of at most 16 words, 64 bytes per word.
    task automatic plan(input logic [31:0] base, input int num);
        logic [31:0] a;
        int rem, l;
        exp_bursts.delete();
        a = base;
        rem = num;
        while (rem > 0) begin
            l = (rem < 16) ? rem : 16;
            exp_bursts.push_back('{addr: a, len: l});
            a = a + 32'(l * 64);
            rem -= l;
        end
    endtask

    task automatic step();
        bit v, a, r, exp_done;
        int res;
        logic [DW-1:0] w;
        @(posedge clk_data); #1;
        chk("credits", dut.credits_q, model_credits);
        if (chk5) begin chk("cred_simul", dut.credits_q, 5); chk5 = 0; end
        chk("vld_lat", sc_in_vld, drove_vld);
        if (sc_in_vld) begin
            if (exp_data.size() == 0) chk("extra_word", sc_in_vld, 0);
            else chk("sc_in", sc_in, exp_data.pop_front());
            delivered++;
            fifo_occ++;
        end
        exp_done = job_active && (job_num == 0 || (sc_in_vld && delivered == job_num));
        chk("done", done, exp_done);
        chk("busy", busy, job_active && !exp_done);
        if (exp_done) job_active = 0;
        if (mem_rd_req) begin
            req_age++;
            if (exp_bursts.size() == 0) chk("req_extra", mem_rd_req, 0);
            else begin
                chk("rd_addr", mem_rd_addr, exp_bursts[0].addr);
                chk("rd_len", mem_rd_len, exp_bursts[0].len);
                chk("req_credit", mem_rd_req, model_credits >= exp_bursts[0].len);
            end
        end else req_age = 0;

        for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
        v = (pending > 0) && ($urandom_range(99) < vld_pct);
        if (v) begin exp_data.push_back(w); pending--; end
        a = 0; res = 0;
        if (mem_rd_req && exp_bursts.size() > 0 && req_age >= ack_wait && $urandom_range(99) < ack_pct) begin
            a = 1;
            res = exp_bursts[0].len;
            pending += res;
            void'(exp_bursts.pop_front());
        end
        r = 0;
        if (rtn_force > 0) begin
            r = 1; rtn_force--;
            if (fifo_occ > 0) fifo_occ--;
        end else if (rtn_on_ack && a) begin
            r = 1; chk5 = 1; rtn_on_ack = 0; fifo_occ--;
        end else if (rtn_en && fifo_occ > 0 && $urandom_range(99) < rtn_pct) begin
            r = 1; fifo_occ--;
        end
        model_credits = model_credits + int'(r) - res;
        if (model_credits > 128) model_credits = 128;

        start = 0;
        if (start_req) begin
            start = 1; base_addr = start_base; num_words = 16'(start_num); start_req = 0;
            if (!job_active) begin
                plan(start_base, start_num);
                job_active = 1; job_num = start_num; delivered = 0;
            end
        end else if (junk_en && job_active && $urandom_range(19) == 0) begin
            start = 1; base_addr = $urandom; num_words = 16'($urandom_range(1, 99));
        end
        mem_rd_vld = v; mem_rd_data = w; mem_rd_ack = a; sc_credit_rtn = r; drove_vld = v;
    endtask

    task automatic run_job(input logic [31:0] base, input int num, input int budget);
        int n;
        start_base = base; start_num = num; start_req = 1;
        step();
        n = 0;
        while (job_active && n < budget) begin step(); n++; end
        if (job_active) begin chk("timeout", job_active, 0); job_active = 0; end
        step();
    endtask

    initial begin
        logic [31:0] b;
        int n;
        rst = 1; start = 0; base_addr = '0; num_words = '0; mem_rd_ack = 0;
        mem_rd_data = '0; mem_rd_vld = 0; sc_credit_rtn = 0;
        repeat (3) @(posedge clk_data);
        #1;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_req", mem_rd_req, 0);
        chk("rst_addr", mem_rd_addr, 0); chk("rst_len", mem_rd_len, 0);
        chk("rst_sc_in", sc_in, 0); chk("rst_vld", sc_in_vld, 0); chk("rst_cred", dut.credits_q, 128);
        rst = 0;

        run_job(32'h1000, 40, 400);
        run_job(32'h2000, 0, 5);

        for (int i = 0; i < 6; i++) begin
            ack_pct = $urandom_range(30, 100); vld_pct = $urandom_range(30, 100);
            rtn_pct = $urandom_range(30, 100); ack_wait = $urandom_range(0, 3); junk_en = 1;
            b = $urandom; b[5:0] = '0;
            if (i == 0) run_job(32'hFFFF_FF00, 40, 3000);
            else run_job(b, $urandom_range(1, 60), 3000);
        end
        junk_en = 0; rtn_pct = 100;

        ack_pct = 100; ack_wait = 7; vld_pct = 50;
        run_job(32'h4000, 20, 1000);
        ack_wait = 0; vld_pct = 100;

        // Credit stall: no returns, delivery must stop at the FIFO depth.
        repeat (200) step();
        rtn_en = 0;
        start_base = 32'h8000; start_num = 200; start_req = 1;
        step();
        n = 0;
        while (delivered < 128 && n < 400) begin step(); n++; end
        chk("stall_cnt", delivered, 128);
        repeat (20) begin step(); chk("stall_req", mem_rd_req, 0); end
        rtn_force = 16;
        n = 0;
        do begin step(); n++; end while (!mem_rd_req && n < 40);
        chk("resume_req", mem_rd_req, 1);
        chk("resume_len", mem_rd_len, 16);
        rtn_en = 1;
        n = 0;
        while (job_active && n < 2000) begin step(); n++; end
        if (job_active) begin chk("timeout", job_active, 0); job_active = 0; end
        repeat (200) step();

        // Same-cycle return and reservation, then saturation of excess returns.
        rtn_en = 0;
        run_job(32'hA000, 108, 1000);
        chk("cred_20", dut.credits_q, 20);
        rtn_on_ack = 1;
        run_job(32'hB000, 16, 200);
        rtn_force = 140;
        repeat (142) step();
        chk("cred_sat", dut.credits_q, 128);
        fifo_occ = 0; rtn_en = 1;

        // Reset in the middle of a burst.
        start_base = 32'hC000; start_num = 16; start_req = 1;
        step();
        n = 0;
        while (delivered < 5 && n < 50) begin step(); n++; end
        rst = 1; mem_rd_vld = 0; mem_rd_ack = 0; start = 0; sc_credit_rtn = 0;
        @(posedge clk_data); #1;
        chk("mr_busy", busy, 0); chk("mr_done", done, 0); chk("mr_req", mem_rd_req, 0);
        chk("mr_addr", mem_rd_addr, 0); chk("mr_len", mem_rd_len, 0); chk("mr_sc_in", sc_in, 0);
        chk("mr_vld", sc_in_vld, 0); chk("mr_cred", dut.credits_q, 128);
        exp_bursts.delete(); exp_data.delete();
        pending = 0; drove_vld = 0; job_active = 0; model_credits = 128; fifo_occ = 0; req_age = 0;
        rst = 0; mem_rd_vld = 1; mem_rd_data = {16{32'hDEAD_BEEF}};
        repeat (3) begin
            @(posedge clk_data); #1;
            chk("stray_vld", sc_in_vld, 0);
            chk("stray_req", mem_rd_req, 0);
        end
        mem_rd_vld = 0;
        step();
        run_job(32'hD000, 33, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sc_fetch.md
# sc_fetch

Shortcut-data fetch engine on the `clk_data` side of the shortcut path. It issues burst reads of 512-bit shortcut feature-map words from external memory and streams them onto `sc_in`/`sc_in_vld`, which feed the shortcut FIFO write port. Flow control uses a credit counter that mirrors free FIFO entries, so the FIFO is never overrun.

## Interface
- `BITWIDTH`, 32, element width; one word is `BITWIDTH*16` bits (512 at default).
- `ADDR_W`, 32, byte-address width.
- `LEN_W`, 16, width of the word-count field.
- `BURST_LEN`, 16, maximum words per memory burst (power of 2, ≤ `FIFO_DEPTH`).
- `FIFO_DEPTH`, 128, entries in the downstream shortcut FIFO; the initial credit count.

Ports:
- `clk_data`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; honoured only in IDLE.
- `base_addr`  in  ADDR_W  start byte address, sampled with `start`; 64-byte aligned.
- `num_words`  in  LEN_W  words to fetch, sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `mem_rd_req`  out  1  burst read request.
- `mem_rd_addr`  out  ADDR_W  burst byte address.
- `mem_rd_len`  out  $clog2(BURST_LEN)+1  burst length in words (1..BURST_LEN).
- `mem_rd_ack`  in  1  request accepted in the cycle where `mem_rd_req & mem_rd_ack`.
- `mem_rd_data`  in  BITWIDTH*16  read return data.
- `mem_rd_vld`  in  1  return word valid.
- `sc_credit_rtn`  in  1  one FIFO entry freed; already synchronised to `clk_data`.
- `sc_in`  out  BITWIDTH*16  data to the shortcut FIFO.
- `sc_in_vld`  out  1  FIFO write strobe.

## Operation
- FSM states: IDLE, REQ, RECV, DONE.
- IDLE: `start` latches `base_addr` into `addr` and `num_words` into `remain`. If `num_words==0`, go to DONE; otherwise go to REQ.
- REQ: `cur_len = min(BURST_LEN, remain)`. Assert `mem_rd_req` only when `credits >= cur_len`. `mem_rd_addr`/`mem_rd_len` are stable while req is high. On `req & ack`:
  - `credits -= cur_len`
  - `addr += cur_len*64`
  - `remain -= cur_len`
  - `rx_cnt = cur_len`
  - go to RECV.
- RECV: each `mem_rd_vld` decrements `rx_cnt` and forwards the word. When the last word is received, go to REQ if `remain != 0`, else go to DONE. `mem_rd_vld` outside RECV is ignored (no write to `sc_in_vld`).
- DONE: `done=1` for one cycle, `busy=0`, next state IDLE.
- Credits:
  - Width is $clog2(FIFO_DEPTH)+1; reset value is FIFO_DEPTH.
  - Net update per cycle is `+sc_credit_rtn - (ack ? cur_len : 0)`, applied in one adder, so simultaneous return and reservation are both counted.
  - The count saturates at FIFO_DEPTH; excess returns are dropped.
  - Credits persist across jobs.
- `start` in any state other than IDLE is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - all outputs 0, including `sc_in`
  - state IDLE, credits FIFO_DEPTH, all counters 0.
- `rst` mid-job aborts immediately: no further req or vld, and no `done`. `rst` must be asserted together with the downstream FIFO clear.
- `start` at cycle t puts the FSM in REQ at t+1; `busy=1` and `mem_rd_req` are eligible at t+1.
- `ack` at cycle a puts the FSM in RECV at a+1; `mem_rd_req` drops at a+1.
- `mem_rd_vld` at cycle r (in RECV) produces `sc_in_vld=1` with `sc_in=mem_rd_data` at r+1. Latency is exactly 1 cycle and back-to-back words are passed every cycle.
- If the last word arrives at cycle r, the FSM enters DONE at r+1, so `done` is high in the same cycle as the last `sc_in_vld`. The FSM is in IDLE at r+2.
- `num_words==0`: `start` at t gives `done` at t+1 with no memory traffic.

## Test plan
- Single job: `base_addr=0x1000`, `num_words=40`, immediate ack and return, credits returned promptly -> bursts (addr,len) = (0x1000,16), (0x1400,16), (0x1800,8); 40 `sc_in_vld` in order, each 1 cycle after its `mem_rd_vld`; one `done`.
- Credit stall: `num_words=200`, no `sc_credit_rtn` -> exactly 128 words delivered, then `mem_rd_req` stays low. Then 16 `sc_credit_rtn` pulses -> the next burst of 16 issues.
- Simultaneous events: `sc_credit_rtn` in the same cycle as an ack of len 16 with credits=20 -> credits=5 the next cycle. 140 returns with zero outstanding -> saturate at 128.
- `num_words=0` -> `done` at t+1, no req. `start` pulsed while busy -> ignored, job unchanged.
- Reset mid-RECV (after 5 of 16 words) -> all outputs 0 the next cycle, credits=128, later stray `mem_rd_vld` produces no `sc_in_vld`. A new `start` then runs correctly.
- Delayed ack (req held 7 cycles) with gapped `mem_rd_vld` -> addr/len stable until ack, no lost or duplicated words.
